// File: rtl/ddr3_arb_pkg.sv
// ----------------------------------------------------------------------------
// ddr3_arb_pkg
// Shared constants, the arbiter state type and a one-hot decode helper used
// by the DDR3 write-port arbiter (ddr3_wr_arb) and its round-robin picker.
// No ports.
// ----------------------------------------------------------------------------
package ddr3_arb_pkg;

    localparam int unsigned NUM_CHAN   = 5;
    localparam int unsigned WFM_CNT_W  = 24;
    localparam int unsigned CHAN_IDX_W = 3;

    typedef enum logic [2:0] {
        StIdle,
        StArb,
        StBurst,
        StHeader,
        StDone
    } arb_state_e;

    // Index of the set bit in a one-hot channel vector (0 when none set).
    function automatic logic [CHAN_IDX_W-1:0] onehot_idx(input logic [NUM_CHAN-1:0] oh);
        logic [CHAN_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_CHAN; i++) begin
            if (oh[i]) idx = CHAN_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin winner select. The search starts at the channel
// after i_last_gnt and wraps; the first requesting channel wins.
// Ports:
//   i_req       [NUM_CHAN-1:0]   per-channel request
//   i_last_gnt  [CHAN_IDX_W-1:0] index of the previously granted channel
//   o_gnt       [NUM_CHAN-1:0]   one-hot winner, zero when no request
// ----------------------------------------------------------------------------
module rr_pick
    import ddr3_arb_pkg::*;
(
    input  logic [NUM_CHAN-1:0]   i_req,
    input  logic [CHAN_IDX_W-1:0] i_last_gnt,
    output logic [NUM_CHAN-1:0]   o_gnt
);

    logic [CHAN_IDX_W-1:0] w_sh;
    logic [NUM_CHAN-1:0]   w_rot;
    logic [NUM_CHAN-1:0]   w_iso;
    logic [2*NUM_CHAN-1:0] w_back;

    // Rotate so the first candidate sits at bit 0, isolate the lowest set
    // bit, then rotate back to channel positions.
    always_comb begin
        w_sh   = i_last_gnt + CHAN_IDX_W'(1);
        w_rot  = NUM_CHAN'({i_req, i_req} >> w_sh);
        w_iso  = w_rot & (-w_rot);
        w_back = {{NUM_CHAN{1'b0}}, w_iso} << w_sh;
        o_gnt  = w_back[2*NUM_CHAN-1:NUM_CHAN] | w_back[NUM_CHAN-1:0];
    end

endmodule

// File: rtl/ddr3_wr_arb.sv
// ----------------------------------------------------------------------------
// ddr3_wr_arb
// Arbitrates the shared DDR3 FIFO write port between five acquisition
// channels during a fill window, then requests the fill header and flags
// completion. Counts written waveforms and latches protocol errors.
// Ports:
//   adc_clk          acquisition clock (rising edge)
//   reset_clk_adc_n  asynchronous active-low reset
//   ddr3_wr_en       fill window; low aborts / ends the fill
//   cbuf_rd_en       low: no further waveforms will be requested this fill
//   ch_req[4:0]      per-channel waveform ready
//   ch_wr[4:0]       per-channel word strobe into the FIFO
//   ch_last[4:0]     per-channel last-word flag (qualified by ch_wr)
//   fifo_afull       FIFO almost full; blocks new grants only
//   hdr_done         header writer finished (pulse)
//   ch_gnt[4:0]      one-hot write-port grant
//   hdr_req          header request level
//   ddr3_wr_done     fill complete
//   wfm_cnt[23:0]    waveforms written this fill (saturating)
//   arb_err          sticky protocol error
// ----------------------------------------------------------------------------
module ddr3_wr_arb
    import ddr3_arb_pkg::*;
(
    input  logic                 adc_clk,
    input  logic                 reset_clk_adc_n,
    input  logic                 ddr3_wr_en,
    input  logic                 cbuf_rd_en,
    input  logic [NUM_CHAN-1:0]  ch_req,
    input  logic [NUM_CHAN-1:0]  ch_wr,
    input  logic [NUM_CHAN-1:0]  ch_last,
    input  logic                 fifo_afull,
    input  logic                 hdr_done,
    output logic [NUM_CHAN-1:0]  ch_gnt,
    output logic                 hdr_req,
    output logic                 ddr3_wr_done,
    output logic [WFM_CNT_W-1:0] wfm_cnt,
    output logic                 arb_err
);

    arb_state_e            r_state, w_state_d;
    logic [NUM_CHAN-1:0]   r_ch_gnt, w_ch_gnt_d;
    logic                  r_hdr_req, w_hdr_req_d;
    logic                  r_done, w_done_d;
    logic                  r_arb_err, w_arb_err_d;
    logic [WFM_CNT_W-1:0]  r_wfm_cnt, w_wfm_cnt_d;
    logic [CHAN_IDX_W-1:0] r_last_gnt, w_last_gnt_d;

    logic [NUM_CHAN-1:0]   w_pick;
    logic                  w_burst_end;
    logic                  w_stray_wr;
    logic                  w_stray_hdr;

    rr_pick u_rr_pick (
        .i_req      (ch_req),
        .i_last_gnt (r_last_gnt),
        .o_gnt      (w_pick)
    );

    // Only the granted channel's last word ends a burst; any strobe from a
    // non-granted channel (including a simultaneous ch_last) is an error.
    assign w_burst_end = |(ch_wr & ch_last & r_ch_gnt);
    assign w_stray_wr  = |(ch_wr & ~r_ch_gnt);
    assign w_stray_hdr = hdr_done && (r_state != StHeader);

    always_comb begin
        w_state_d    = r_state;
        w_ch_gnt_d   = r_ch_gnt;
        w_hdr_req_d  = r_hdr_req;
        w_done_d     = r_done;
        w_wfm_cnt_d  = r_wfm_cnt;
        w_last_gnt_d = r_last_gnt;
        w_arb_err_d  = r_arb_err | w_stray_wr | w_stray_hdr;

        if ((r_state != StIdle) && !ddr3_wr_en) begin
            // Fill window closed: leaving DONE is normal, anything else aborts.
            w_state_d   = StIdle;
            w_ch_gnt_d  = '0;
            w_hdr_req_d = 1'b0;
            w_done_d    = 1'b0;
            if (r_state != StDone) w_arb_err_d = 1'b1;
        end else begin
            case (r_state)
                StIdle: begin
                    w_ch_gnt_d  = '0;
                    w_hdr_req_d = 1'b0;
                    w_done_d    = 1'b0;
                    if (ddr3_wr_en) begin
                        w_state_d   = StArb;
                        w_wfm_cnt_d = '0;
                        w_arb_err_d = 1'b0;
                    end
                end
                StArb: begin
                    // Pending requests win over the header, even if blocked.
                    if ((ch_req != '0) && !fifo_afull) begin
                        w_state_d  = StBurst;
                        w_ch_gnt_d = w_pick;
                    end else if (!cbuf_rd_en && (ch_req == '0)) begin
                        w_state_d   = StHeader;
                        w_hdr_req_d = 1'b1;
                    end
                end
                StBurst: begin
                    if (w_burst_end) begin
                        w_state_d    = StArb;
                        w_ch_gnt_d   = '0;
                        w_last_gnt_d = onehot_idx(r_ch_gnt);
                        if (r_wfm_cnt != {WFM_CNT_W{1'b1}}) begin
                            w_wfm_cnt_d = r_wfm_cnt + WFM_CNT_W'(1);
                        end
                    end
                end
                StHeader: begin
                    if (hdr_done) begin
                        w_state_d   = StDone;
                        w_hdr_req_d = 1'b0;
                        w_done_d    = 1'b1;
                    end
                end
                StDone: begin
                    w_done_d = 1'b1;
                end
                default: begin
                    w_state_d   = StIdle;
                    w_ch_gnt_d  = '0;
                    w_hdr_req_d = 1'b0;
                    w_done_d    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge adc_clk or negedge reset_clk_adc_n) begin
        if (!reset_clk_adc_n) begin
            r_state    <= StIdle;
            r_ch_gnt   <= '0;
            r_hdr_req  <= 1'b0;
            r_done     <= 1'b0;
            r_wfm_cnt  <= '0;
            r_arb_err  <= 1'b0;
            r_last_gnt <= CHAN_IDX_W'(NUM_CHAN - 1);
        end else begin
            r_state    <= w_state_d;
            r_ch_gnt   <= w_ch_gnt_d;
            r_hdr_req  <= w_hdr_req_d;
            r_done     <= w_done_d;
            r_wfm_cnt  <= w_wfm_cnt_d;
            r_arb_err  <= w_arb_err_d;
            r_last_gnt <= w_last_gnt_d;
        end
    end

    assign ch_gnt       = r_ch_gnt;
    assign hdr_req      = r_hdr_req;
    assign ddr3_wr_done = r_done;
    assign wfm_cnt      = r_wfm_cnt;
    assign arb_err      = r_arb_err;

endmodule

// File: tb/tb_ddr3_wr_arb.sv
// ----------------------------------------------------------------------------
// tb_ddr3_wr_arb
// Self-checking bench for ddr3_wr_arb. Expected grant order is queued as
// stimulus is applied; a monitor pops and compares on every new grant.
// ----------------------------------------------------------------------------
module tb_ddr3_wr_arb;

    logic        adc_clk         = 1'b0;
    logic        reset_clk_adc_n = 1'b0;
    logic        ddr3_wr_en      = 1'b0;
    logic        cbuf_rd_en      = 1'b0;
    logic [4:0]  ch_req          = '0;
    logic [4:0]  ch_wr           = '0;
    logic [4:0]  ch_last         = '0;
    logic        fifo_afull      = 1'b0;
    logic        hdr_done        = 1'b0;
    logic [4:0]  ch_gnt;
    logic        hdr_req;
    logic        ddr3_wr_done;
    logic [23:0] wfm_cnt;
    logic        arb_err;

    int         n_vec = 0;
    int         n_err = 0;
    int         q_gnt[$];
    logic       mon_en   = 1'b0;
    logic [4:0] prev_gnt = '0;

    ddr3_wr_arb dut (
        .adc_clk         (adc_clk),
        .reset_clk_adc_n (reset_clk_adc_n),
        .ddr3_wr_en      (ddr3_wr_en),
        .cbuf_rd_en      (cbuf_rd_en),
        .ch_req          (ch_req),
        .ch_wr           (ch_wr),
        .ch_last         (ch_last),
        .fifo_afull      (fifo_afull),
        .hdr_done        (hdr_done),
        .ch_gnt          (ch_gnt),
        .hdr_req         (hdr_req),
        .ddr3_wr_done    (ddr3_wr_done),
        .wfm_cnt         (wfm_cnt),
        .arb_err         (arb_err)
    );

    always #5 adc_clk = ~adc_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Grant monitor: one-hot always, and each new grant matches the queue.
    always @(negedge adc_clk) begin
        if (mon_en) begin
            check_eq("gnt_onehot0", 32'($onehot0(ch_gnt)), 32'd1);
            if ((ch_gnt != '0) && (prev_gnt == '0)) begin
                if (q_gnt.size() == 0) begin
                    check_eq("gnt_unexpected", 32'(ch_gnt), 32'd0);
                end else begin
                    int e;
                    e = q_gnt.pop_front();
                    check_eq("gnt_order", 32'(ch_gnt), 32'd1 << e);
                end
            end
        end
        prev_gnt = ch_gnt;
    end

    task automatic step(input int n);
        repeat (n) @(negedge adc_clk);
    endtask

    task automatic wait_gnt(input int ch);
        logic [4:0] m;
        m = 5'd1 << ch;
        for (int k = 0; k < 20; k++) begin
            if ((ch_gnt & m) != '0) break;
            step(1);
        end
        check_eq("gnt_wait", 32'(ch_gnt), 32'(m));
    endtask

    // Drive a granted burst; checks grant holds and drops with a gap cycle.
    task automatic burst(input int ch, input int nwords);
        logic [4:0] m;
        m = 5'd1 << ch;
        for (int i = 0; i < nwords; i++) begin
            ch_wr   = m;
            ch_last = (i == nwords - 1) ? m : 5'd0;
            step(1);
            if (i < nwords - 1) check_eq("gnt_held", 32'(ch_gnt), 32'(m));
        end
        ch_wr   = '0;
        ch_last = '0;
        check_eq("gap_after_burst", 32'(ch_gnt), 32'd0);
    endtask

    task automatic wait_hdr();
        for (int k = 0; k < 10; k++) begin
            if (hdr_req) break;
            step(1);
        end
        check_eq("hdr_req_wait", 32'(hdr_req), 32'd1);
    endtask

    initial begin
        // Reset state
        step(1);
        check_eq("rst_gnt", 32'(ch_gnt), 32'd0);
        check_eq("rst_hdr", 32'(hdr_req), 32'd0);
        check_eq("rst_done", 32'(ddr3_wr_done), 32'd0);
        check_eq("rst_cnt", 32'(wfm_cnt), 32'd0);
        check_eq("rst_err", 32'(arb_err), 32'd0);
        reset_clk_adc_n = 1'b1;
        cbuf_rd_en      = 1'b1;

        // Round-robin with all channels requesting
        mon_en     = 1'b1;
        ddr3_wr_en = 1'b1;
        ch_req     = 5'b11111;
        for (int k = 0; k < 6; k++) q_gnt.push_back(k % 5);
        for (int k = 0; k < 6; k++) begin
            wait_gnt(k % 5);
            if (k == 5) ch_req = '0;
            burst(k % 5, 4);
        end
        check_eq("rr_cnt", 32'(wfm_cnt), 32'd6);
        check_eq("rr_err", 32'(arb_err), 32'd0);

        // Back-pressure: no grant while afull, grant one cycle after it falls
        fifo_afull = 1'b1;
        ch_req     = 5'b00100;
        q_gnt.push_back(2);
        for (int k = 0; k < 3; k++) begin
            step(1);
            check_eq("afull_block", 32'(ch_gnt), 32'd0);
        end
        fifo_afull = 1'b0;
        step(1);
        check_eq("afull_release", 32'(ch_gnt), 32'b00100);
        ch_req = '0;
        // afull mid-burst does not revoke the grant
        ch_wr = 5'b00100;
        step(1);
        fifo_afull = 1'b1;
        step(1);
        check_eq("afull_hold1", 32'(ch_gnt), 32'b00100);
        step(1);
        check_eq("afull_hold2", 32'(ch_gnt), 32'b00100);
        ch_last = 5'b00100;
        step(1);
        ch_wr      = '0;
        ch_last    = '0;
        fifo_afull = 1'b0;
        check_eq("afull_end_gnt", 32'(ch_gnt), 32'd0);
        check_eq("afull_cnt", 32'(wfm_cnt), 32'd7);

        // Fill end: pending channel 1 first, then header, then done
        ch_req     = 5'b00010;
        cbuf_rd_en = 1'b0;
        q_gnt.push_back(1);
        wait_gnt(1);
        check_eq("fill_no_hdr", 32'(hdr_req), 32'd0);
        ch_req = '0;
        burst(1, 2);
        wait_hdr();
        check_eq("hdr_no_gnt", 32'(ch_gnt), 32'd0);
        hdr_done = 1'b1;
        step(1);
        hdr_done = 1'b0;
        check_eq("done_set", 32'(ddr3_wr_done), 32'd1);
        check_eq("done_hdr_clr", 32'(hdr_req), 32'd0);
        check_eq("done_cnt", 32'(wfm_cnt), 32'd8);
        check_eq("done_err", 32'(arb_err), 32'd0);
        step(2);
        check_eq("done_hold", 32'(ddr3_wr_done), 32'd1);
        ddr3_wr_en = 1'b0;
        step(1);
        check_eq("idle_done", 32'(ddr3_wr_done), 32'd0);
        check_eq("idle_gnt", 32'(ch_gnt), 32'd0);
        check_eq("idle_hdr", 32'(hdr_req), 32'd0);
        check_eq("idle_err", 32'(arb_err), 32'd0);
        cbuf_rd_en = 1'b1;

        // Abort mid-burst
        ddr3_wr_en = 1'b1;
        step(1);
        check_eq("start_cnt_clr", 32'(wfm_cnt), 32'd0);
        ch_req = 5'b01000;
        q_gnt.push_back(3);
        wait_gnt(3);
        ch_req = '0;
        ch_wr  = 5'b01000;
        step(1);
        ddr3_wr_en = 1'b0;
        ch_wr      = '0;
        step(1);
        check_eq("abort_gnt", 32'(ch_gnt), 32'd0);
        check_eq("abort_err", 32'(arb_err), 32'd1);
        for (int k = 0; k < 3; k++) begin
            check_eq("abort_no_hdr", 32'(hdr_req), 32'd0);
            step(1);
        end
        ddr3_wr_en = 1'b1;
        step(1);
        check_eq("restart_err", 32'(arb_err), 32'd0);
        check_eq("restart_cnt", 32'(wfm_cnt), 32'd0);

        // Strobe from a non-granted channel
        ch_req = 5'b00001;
        q_gnt.push_back(0);
        wait_gnt(0);
        ch_req = '0;
        ch_wr  = 5'b01000;
        step(1);
        ch_wr = '0;
        check_eq("stray_err", 32'(arb_err), 32'd1);
        check_eq("stray_cnt", 32'(wfm_cnt), 32'd0);
        step(1);
        check_eq("stray_sticky", 32'(arb_err), 32'd1);
        burst(0, 1);
        check_eq("stray_cnt_after", 32'(wfm_cnt), 32'd1);
        check_eq("stray_sticky2", 32'(arb_err), 32'd1);

        // Saturation: preload near the top and run two more bursts
        force dut.r_wfm_cnt = 24'hFFFFFE;
        step(1);
        release dut.r_wfm_cnt;
        step(1);
        check_eq("preload_cnt", 32'(wfm_cnt), 32'hFFFFFE);
        ch_req = 5'b00010;
        q_gnt.push_back(1);
        wait_gnt(1);
        ch_req = '0;
        burst(1, 1);
        check_eq("cnt_top", 32'(wfm_cnt), 32'hFFFFFF);
        ch_req = 5'b00100;
        q_gnt.push_back(2);
        wait_gnt(2);
        ch_req = '0;
        burst(2, 1);
        check_eq("cnt_sat", 32'(wfm_cnt), 32'hFFFFFF);

        // Async reset between edges while in HEADER
        ddr3_wr_en = 1'b0;
        step(1);
        ddr3_wr_en = 1'b1;
        cbuf_rd_en = 1'b0;
        step(1);
        wait_hdr();
        @(posedge adc_clk);
        #2;
        reset_clk_adc_n = 1'b0;
        #1;
        check_eq("arst_hdr", 32'(hdr_req), 32'd0);
        check_eq("arst_gnt", 32'(ch_gnt), 32'd0);
        step(1);
        check_eq("arst_done", 32'(ddr3_wr_done), 32'd0);
        check_eq("arst_cnt", 32'(wfm_cnt), 32'd0);
        reset_clk_adc_n = 1'b1;
        cbuf_rd_en      = 1'b1;
        ch_req          = 5'b11111;
        q_gnt.push_back(0);
        wait_gnt(0);
        ch_req = '0;
        burst(0, 1);
        step(2);
        check_eq("queue_drained", 32'(q_gnt.size()), 32'd0);
        mon_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ddr3_wr_arb.md
DDR3_WR_ARB -- requirements
Module: ddr3_wr_arb

Interface
REQ-001 adc_clk  in  1  acquisition clock; all logic on rising edge.
REQ-002 reset_clk_adc_n  in  1  asynchronous, active-low reset.
REQ-003 ddr3_wr_en  in  1  fill window from the acquisition state machine; arbitration is allowed only while high.
REQ-004 cbuf_rd_en  in  1  circular-buffer read enable; low means no new waveforms will be requested this fill.
REQ-005 ch_req  in  5  per-channel request: a triggered waveform is ready to move to DDR3.
REQ-006 ch_wr  in  5  per-channel word strobe into the DDR3 FIFO.
REQ-007 ch_last  in  5  per-channel last-word flag, qualified by ch_wr.
REQ-008 fifo_afull  in  1  DDR3 FIFO almost full.
REQ-009 hdr_done  in  1  fill header and checksum writer finished; one-cycle pulse.
REQ-010 ch_gnt  out  5  one-hot grant of the shared FIFO write port; all zeros when no grant.
REQ-011 hdr_req  out  1  level request to the fill-header writer.
REQ-012 ddr3_wr_done  out  1  fill fully written to DDR3.
REQ-013 wfm_cnt  out  24  waveforms written in the current fill.
REQ-014 arb_err  out  1  sticky protocol error.

Function
REQ-015 States: IDLE, ARB, BURST, HEADER, DONE.
REQ-016 IDLE->ARB when ddr3_wr_en=1. On this transition wfm_cnt clears to 0 and arb_err clears to 0.
REQ-017 ARB->BURST when ch_req!=0 and fifo_afull=0. ch_gnt goes one-hot to the winner on the same edge, so the grant is visible one cycle after the request is sampled.
REQ-018 Winner selection is round-robin. Search starts at (last_gnt+1) mod 5. last_gnt resets to 4, so channel 0 has first priority.
REQ-019 ARB->HEADER when cbuf_rd_en=0 and ch_req=0. If requests are present, servicing them takes precedence over the header.
REQ-020 BURST->ARB on ch_wr[g]&ch_last[g] for the granted channel g.
- ch_gnt clears on the same edge.
- last_gnt updates to g.
- No grant is issued in the cycle immediately after a burst ends.
REQ-021 fifo_afull does not revoke an active grant; the granted channel throttles itself.
REQ-022 HEADER:
- hdr_req=1.
- HEADER->DONE on hdr_done, and hdr_req clears on the same edge.
REQ-023 DONE: ddr3_wr_done=1. DONE->IDLE when ddr3_wr_en=0.
REQ-024 In any state except IDLE, ddr3_wr_en=0 aborts the fill:
- next state is IDLE;
- ch_gnt and hdr_req clear on the next edge;
- no header is requested;
- arb_err sets, except when aborting from DONE.
REQ-025 wfm_cnt increments on ch_wr[g]&ch_last[g] of the granted channel and saturates at 24'hFFFFFF.
REQ-026 arb_err sets on ch_wr from a channel that is not granted, and on hdr_done outside HEADER. It holds until the next IDLE->ARB transition or reset.
REQ-027 If several ch_last bits assert at once, only the granted channel's bit counts. The rest set arb_err, per REQ-026.
REQ-028 All outputs are registered; there are no combinational paths from inputs to outputs.

Reset
REQ-029 Asserting reset_clk_adc_n low immediately forces:
- state IDLE;
- ch_gnt=0, hdr_req=0, ddr3_wr_done=0;
- wfm_cnt=0, arb_err=0;
- last_gnt=4.
REQ-030 Reset asserted mid-burst or mid-header takes effect immediately, with no pending request retained. Reset deassertion is synchronized externally to adc_clk.

Structure
REQ-031 A shared package ddr3_arb_pkg holds NUM_CHAN=5, WFM_CNT_W=24 and the state enumeration.
REQ-032 A combinational sub-module rr_pick takes (req, last_gnt) and returns the one-hot winner. The FSM, counter and error flag stay in ddr3_wr_arb.
REQ-033 Target size is 120-400 RTL lines.

Verification
REQ-034 Round-robin order:
- Stimulus: ddr3_wr_en=1; ch_req=5'b11111 held; each burst is 4 words.
- Required: grants go 0,1,2,3,4,0; ch_gnt is one-hot throughout; wfm_cnt=6 after 6 bursts.
REQ-035 Back-pressure:
- Case A: fifo_afull=1 while in ARB with ch_req=5'b00100. Required: no grant while fifo_afull=1; ch_gnt=5'b00100 one cycle after fifo_afull falls.
- Case B: fifo_afull rises mid-burst. Required: the grant is held.
REQ-036 Fill end:
- Stimulus: cbuf_rd_en drops with ch_req=5'b00010 pending.
- Required: channel 1 is serviced first; then hdr_req=1; hdr_done pulse gives ddr3_wr_done=1; ddr3_wr_en=0 returns to IDLE with all outputs 0.
REQ-037 Abort:
- Stimulus: ddr3_wr_en drops mid-burst.
- Required: ch_gnt=0 next cycle; arb_err=1; hdr_req never asserts; next fill start clears arb_err and wfm_cnt.
REQ-038 Protocol error:
- Case A: ch_wr[3] pulses while ch_gnt=5'b00001. Required: arb_err=1 next cycle and stays 1; wfm_cnt unchanged.
- Case B: counter preloaded to 24'hFFFFFF, then one more ch_last. Required: wfm_cnt stays 24'hFFFFFF.
REQ-039 Async reset:
- Stimulus: reset_clk_adc_n low mid-HEADER, between clock edges.
- Required: hdr_req=0 before the next edge; the first fill after release grants channel 0 first.
